// File: rtl/rx_serial_sonar_7e1.sv
// 7E1 serial receiver plus "AAA,DDD#" frame parser for the sonar telemetry link.
// Angle and distance come out as 3-digit BCD, with one-cycle status pulses.
module rx_serial_sonar_7e1 #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        entrada_serial,
    output logic [11:0] angulo,
    output logic [11:0] medida,
    output logic        pronto,
    output logic        erro_paridade,
    output logic        erro_formato,
    output logic [3:0]  db_estado
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    // Start-bit sample lands 2 synchronizer cycles + CLKS_PER_BIT/2 after the pin falls;
    // detection and the first INICIO cycle account for two of those cycles.
    localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 2);
    localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [3:0] {
        OCIOSO   = 4'd0,
        INICIO   = 4'd1,
        DADOS    = 4'd2,
        PARIDADE = 4'd3,
        PARADA   = 4'd4
    } rx_state_t;

    typedef enum logic {
        RECEBE   = 1'b0,
        DESCARTA = 1'b1
    } parse_state_t;

    logic            sync1_q, sync2_q;
    rx_state_t       rx_state_q;
    logic [TW-1:0]   timer_q;
    logic [2:0]      nbit_q;
    logic [6:0]      data_q;
    logic            par_q;
    logic            stop_q;
    logic            samp_q;
    logic            strobe_q;
    logic [6:0]      char_q;
    logic            bad_q;
    parse_state_t    parse_state_q;
    logic [2:0]      idx_q;
    logic [11:0]     ang_sh_q, med_sh_q;
    logic [11:0]     angulo_q, medida_q;
    logic            pronto_q, erro_par_q, erro_fmt_q;

    logic            is_digit, is_hash, is_comma, legal;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= entrada_serial;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_state_q <= OCIOSO;
            timer_q    <= '0;
            nbit_q     <= '0;
            data_q     <= '0;
            par_q      <= 1'b0;
            stop_q     <= 1'b0;
            samp_q     <= 1'b0;
        end else begin
            samp_q <= 1'b0;
            case (rx_state_q)
                OCIOSO: begin
                    if (!sync2_q) begin
                        timer_q    <= '0;
                        rx_state_q <= INICIO;
                    end
                end
                INICIO: begin
                    if (timer_q == T_HALF) begin
                        timer_q    <= '0;
                        nbit_q     <= '0;
                        rx_state_q <= sync2_q ? OCIOSO : DADOS;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                DADOS: begin
                    if (timer_q == T_FULL) begin
                        timer_q <= '0;
                        data_q  <= {sync2_q, data_q[6:1]};
                        if (nbit_q == 3'd6) rx_state_q <= PARIDADE;
                        else                nbit_q     <= nbit_q + 3'd1;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                PARIDADE: begin
                    if (timer_q == T_FULL) begin
                        timer_q    <= '0;
                        par_q      <= sync2_q;
                        rx_state_q <= PARADA;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                PARADA: begin
                    if (timer_q == T_FULL) begin
                        timer_q    <= '0;
                        stop_q     <= sync2_q;
                        samp_q     <= 1'b1;
                        rx_state_q <= OCIOSO;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                default: rx_state_q <= OCIOSO;
            endcase
        end
    end

    // Character strobe: one cycle after the stop-bit sample, with the checks folded in.
    always_ff @(posedge clock) begin
        if (reset) begin
            strobe_q <= 1'b0;
            char_q   <= '0;
            bad_q    <= 1'b0;
        end else begin
            strobe_q <= samp_q;
            if (samp_q) begin
                char_q <= data_q;
                bad_q  <= (^data_q ^ par_q) | ~stop_q;
            end
        end
    end

    always_comb begin
        is_digit = (char_q[6:4] == 3'b011) && (char_q[3:0] <= 4'd9);
        is_hash  = (char_q == 7'h23);
        is_comma = (char_q == 7'h2C);
        case (idx_q)
            3'd3:    legal = is_comma;
            3'd7:    legal = is_hash;
            default: legal = is_digit;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            parse_state_q <= RECEBE;
            idx_q         <= '0;
            ang_sh_q      <= '0;
            med_sh_q      <= '0;
            angulo_q      <= '0;
            medida_q      <= '0;
            pronto_q      <= 1'b0;
            erro_par_q    <= 1'b0;
            erro_fmt_q    <= 1'b0;
        end else begin
            pronto_q   <= 1'b0;
            erro_par_q <= 1'b0;
            erro_fmt_q <= 1'b0;
            if (strobe_q) begin
                if (parse_state_q == DESCARTA) begin
                    if (is_hash) begin
                        idx_q         <= '0;
                        parse_state_q <= RECEBE;
                    end
                end else if (bad_q || !legal) begin
                    erro_par_q <= bad_q;
                    erro_fmt_q <= !bad_q;
                    // A '#' closes the broken frame itself, so resync immediately.
                    if (is_hash) idx_q         <= '0;
                    else         parse_state_q <= DESCARTA;
                end else if (idx_q == 3'd7) begin
                    angulo_q <= ang_sh_q;
                    medida_q <= med_sh_q;
                    pronto_q <= 1'b1;
                    idx_q    <= '0;
                end else begin
                    case (idx_q)
                        3'd0: ang_sh_q[11:8] <= char_q[3:0];
                        3'd1: ang_sh_q[7:4]  <= char_q[3:0];
                        3'd2: ang_sh_q[3:0]  <= char_q[3:0];
                        3'd4: med_sh_q[11:8] <= char_q[3:0];
                        3'd5: med_sh_q[7:4]  <= char_q[3:0];
                        3'd6: med_sh_q[3:0]  <= char_q[3:0];
                        default: ;
                    endcase
                    idx_q <= idx_q + 3'd1;
                end
            end
        end
    end

    assign angulo        = angulo_q;
    assign medida        = medida_q;
    assign pronto        = pronto_q;
    assign erro_paridade = erro_par_q;
    assign erro_formato  = erro_fmt_q;
    assign db_estado     = rx_state_q;

endmodule

// File: tb/tb_rx_serial_sonar_7e1.sv
// Directed bench for rx_serial_sonar_7e1: 7E1 frames driven bit by bit at 16 clocks/bit,
// pulses counted by a negedge monitor, results checked with immediate assertions.
module tb_rx_serial_sonar_7e1;

    localparam int C = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        entrada_serial = 1'b1;
    logic [11:0] angulo, medida;
    logic        pronto, erro_paridade, erro_formato;
    logic [3:0]  db_estado;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int n_pr, n_ep, n_ef, n_stb, n_ovl, pr_cyc, last_start;
    logic seen_busy;
    logic prev_pr, prev_ep, prev_ef;

    rx_serial_sonar_7e1 #(.CLKS_PER_BIT(C)) dut (
        .clock(clock),
        .reset(reset),
        .entrada_serial(entrada_serial),
        .angulo(angulo),
        .medida(medida),
        .pronto(pronto),
        .erro_paridade(erro_paridade),
        .erro_formato(erro_formato),
        .db_estado(db_estado)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Pulse monitor: counts pulses, flags overlaps and pulses wider than one cycle.
    always @(negedge clock) begin
        if (pronto) begin
            n_pr++;
            pr_cyc = cyc;
        end
        if (erro_paridade) n_ep++;
        if (erro_formato) n_ef++;
        if (dut.strobe_q) n_stb++;
        if (db_estado != 4'd0) seen_busy = 1'b1;
        if ((32'(pronto) + 32'(erro_paridade) + 32'(erro_formato)) > 1) n_ovl++;
        if ((pronto && prev_pr) || (erro_paridade && prev_ep) || (erro_formato && prev_ef)) n_ovl++;
        prev_pr = pronto;
        prev_ep = erro_paridade;
        prev_ef = erro_formato;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        n_pr = 0; n_ep = 0; n_ef = 0; n_stb = 0; pr_cyc = -1; seen_busy = 1'b0;
    endtask

    task automatic send_char(input logic [6:0] ch, input logic flip_par);
        logic [9:0] bits;
        bits = {1'b1, (^ch) ^ flip_par, ch, 1'b0};
        for (int b = 0; b < 10; b++) begin
            @(posedge clock);
            #1;
            entrada_serial = bits[b];
            if (b == 0) last_start = cyc;
            repeat (C - 1) @(posedge clock);
        end
    endtask

    task automatic send_str(input string s, input int bad_idx);
        byte ch;
        for (int i = 0; i < s.len(); i++) begin
            ch = s[i];
            send_char(ch[6:0], i == bad_idx);
        end
    endtask

    task automatic settle();
        repeat (10) @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        n_ovl = 0;
        prev_pr = 0; prev_ep = 0; prev_ef = 0;
        clear_counts();
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_angulo", 32'(angulo), 32'h000);
        chk("rst_medida", 32'(medida), 32'h000);
        chk("rst_pronto", 32'(pronto), 0);
        chk("rst_erros", 32'({erro_paridade, erro_formato}), 0);
        chk("rst_estado", 32'(db_estado), 0);
        @(posedge clock);
        #1 reset = 1'b0;
        repeat (4) @(posedge clock);

        // Valid frame with exact pronto timing: start bit of '#' + 2 + C/2 + 9C + 2
        clear_counts();
        send_str("090,123#", -1);
        settle();
        chk("ok_pronto_cnt", n_pr, 1);
        chk("ok_err_cnt", n_ep + n_ef, 0);
        chk("ok_angulo", 32'(angulo), 32'h090);
        chk("ok_medida", 32'(medida), 32'h123);
        chk("ok_pronto_time", pr_cyc, last_start + 4 + C / 2 + 9 * C);
        chk("ok_strobes", n_stb, 8);

        // Parity error on the 3rd character
        clear_counts();
        send_str("045,200#", 2);
        settle();
        chk("par_ep_cnt", n_ep, 1);
        chk("par_pronto_cnt", n_pr, 0);
        chk("par_ef_cnt", n_ef, 0);
        chk("par_hold_ang", 32'(angulo), 32'h090);
        chk("par_hold_med", 32'(medida), 32'h123);
        clear_counts();
        send_str("135,007#", -1);
        settle();
        chk("par_next_pronto", n_pr, 1);
        chk("par_next_ang", 32'(angulo), 32'h135);
        chk("par_next_med", 32'(medida), 32'h007);

        // Format error at 'X', then recovery
        clear_counts();
        send_str("0X0,111#", -1);
        settle();
        chk("fmt_ef_cnt", n_ef, 1);
        chk("fmt_ep_cnt", n_ep, 0);
        chk("fmt_pronto_cnt", n_pr, 0);
        clear_counts();
        send_str("020,300#", -1);
        settle();
        chk("fmt_next_pronto", n_pr, 1);
        chk("fmt_next_err", n_ep + n_ef, 0);
        chk("fmt_next_ang", 32'(angulo), 32'h020);
        chk("fmt_next_med", 32'(medida), 32'h300);

        // 5-cycle low glitch on the idle line
        clear_counts();
        @(posedge clock);
        #1 entrada_serial = 1'b0;
        repeat (5) @(posedge clock);
        #1 entrada_serial = 1'b1;
        repeat (40) @(posedge clock);
        @(negedge clock);
        chk("gl_seen_start", 32'(seen_busy), 1);
        chk("gl_strobes", n_stb, 0);
        chk("gl_pulses", n_pr + n_ep + n_ef, 0);
        chk("gl_estado", 32'(db_estado), 0);

        // Reset mid-frame
        clear_counts();
        send_str("090,1", -1);
        @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("mid_rst_ang", 32'(angulo), 32'h000);
        chk("mid_rst_med", 32'(medida), 32'h000);
        send_str("23#", -1);
        settle();
        chk("mid_pronto_cnt", n_pr, 0);
        chk("mid_ef_cnt", n_ef, 1);
        chk("mid_ep_cnt", n_ep, 0);
        chk("mid_ang", 32'(angulo), 32'h000);
        clear_counts();
        send_str("077,456#", -1);
        settle();
        chk("mid_next_pronto", n_pr, 1);
        chk("mid_next_ang", 32'(angulo), 32'h077);
        chk("mid_next_med", 32'(medida), 32'h456);

        // Back-to-back frames, no idle bits
        clear_counts();
        send_str("000,000#180,999#", -1);
        settle();
        chk("b2b_pronto_cnt", n_pr, 2);
        chk("b2b_err_cnt", n_ep + n_ef, 0);
        chk("b2b_ang", 32'(angulo), 32'h180);
        chk("b2b_med", 32'(medida), 32'h999);

        chk("pulse_shape", n_ovl, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: observed no end, expected finish");
        $fatal(1, "timeout");
    end

endmodule
